// File: rtl/gmac_rx_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmac_rx_packer_pkg
// Description : Shared types, header layout and helpers for the GMAC RX packer
// Revision    : 1.0 - initial release
// ============================================================================
package gmac_rx_packer_pkg;

  // Bit offsets of the fields inside the 64-bit module header word
  localparam int HDR_BITS         = 64;
  localparam int HDR_WORD_LEN_LSB = 48;
  localparam int HDR_PORT_LSB     = 16;
  localparam int HDR_BYTE_LEN_LSB = 0;

  typedef enum logic [1:0] {
    WR_SYNC = 2'd0,
    WR_IDLE = 2'd1,
    WR_RECV = 2'd2,
    WR_DROP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_HDR  = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [15:0] byte_len;
    logic [15:0] word_len;
  } desc_t;

  // End-of-frame ctrl marker: bit (ctrl_width - n) set for n valid bytes
  function automatic logic [31:0] ctrl_for_nbytes(input logic [5:0] n,
                                                   input logic [5:0] ctrl_width);
    logic [31:0] r;
    r = 32'd0;
    if ((n >= 6'd1) && (n <= ctrl_width)) begin
      r = 32'd1 << (ctrl_width - n);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gmac_rx_packer_rollback_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rollback_fifo
// Description : RAM FIFO with a speculative write pointer that becomes visible
//               to the reader only on commit, and can be rolled back to the
//               last committed point. Show-ahead output register.
// Revision    : 1.0 - initial release
// ============================================================================
module rollback_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic             rollback,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one   = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;     // speculative write pointer
  logic [AW:0]      r_cm_ptr;     // committed pointer, limit for the reader
  logic [AW:0]      r_fetch_ptr;  // next address loaded into the output register
  logic [AW:0]      r_rd_ptr;     // popped pointer; space is only freed on pop
  logic [AW:0]      w_used;
  logic [AW:0]      w_wr_ptr_inc;
  logic             w_wr;
  logic             w_fetch;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign full         = (w_used == c_depth);
  assign w_wr         = wr_en && !full && !rollback;
  assign w_wr_ptr_inc = r_wr_ptr + c_one;
  assign w_fetch      = (r_fetch_ptr != r_cm_ptr) && (!rd_valid || rd_en);

  // Storage write and show-ahead read into the output register
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
    if (w_fetch) begin
      rd_data <= r_mem[r_fetch_ptr[AW-1:0]];
    end
  end

  // Pointer bookkeeping: rollback wins over any write in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      rd_valid    <= 1'b0;
    end else begin
      if (rollback) begin
        r_wr_ptr <= r_cm_ptr;
      end else if (w_wr) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (commit && !rollback) begin
        r_cm_ptr <= w_wr ? w_wr_ptr_inc : r_wr_ptr;
      end
      if (w_fetch) begin
        r_fetch_ptr <= r_fetch_ptr + c_one;
      end
      if (rd_en && rd_valid) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      if (w_fetch) begin
        rd_valid <= 1'b1;
      end else if (rd_en) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gmac_rx_packer.sv
`default_nettype none
// ============================================================================
// Module      : gmac_rx_packer
// Description : Store-and-forward GMAC RX adapter: packs bytes into words,
//               buffers whole frames with commit/rollback, drops bad,
//               oversize and overflowing frames, emits an optional header.
// Revision    : 1.0 - initial release
// ============================================================================
module gmac_rx_packer
  import gmac_rx_packer_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH/8,
  parameter int ENABLE_HEADER   = 1,
  parameter int STAGE_NUMBER    = 'hff,
  parameter int PORT_NUMBER     = 0,
  parameter int DEPTH_WORDS     = 512,
  parameter int LEN_FIFO_DEPTH  = 16,
  parameter int MAX_PKT_BYTES   = 1518,
  parameter int JUMBO_PKT_BYTES = 9018
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_dvld,
  input  logic                  rx_eop,
  input  logic                  rx_err,
  input  logic                  jumbo_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  pkt_good,
  output logic                  pkt_bad,
  output logic                  pkt_dropped
);

  localparam int LANE_W = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;
  localparam int FW     = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [15:0]           c_max_bytes   = 16'(MAX_PKT_BYTES);
  localparam logic [15:0]           c_jumbo_bytes = 16'(JUMBO_PKT_BYTES);
  localparam logic [LANE_W-1:0]     c_last_lane   = LANE_W'(CTRL_WIDTH-1);
  localparam logic [CTRL_WIDTH-1:0] c_stage       = CTRL_WIDTH'(STAGE_NUMBER);
  localparam logic [15:0]           c_port        = 16'(PORT_NUMBER);

  // ---------------- write side ----------------
  wr_state_t               r_wr_state, w_wr_next;
  logic [15:0]             r_cnt, r_wcnt;
  logic [LANE_W-1:0]       r_lane;
  logic [DATA_WIDTH-1:0]   r_word, w_word;
  logic                    r_jumbo;
  logic [15:0]             w_limit, w_cnt_next;
  logic                    w_over, w_word_end, w_is_err, w_ovf;
  logic                    w_accept, w_frame_drop, w_frame_good, w_frame_bad, w_drop_eop;
  logic                    w_data_wr;
  logic [31:0]             w_ctrl32;
  logic                    w_ctrl_unused;
  logic [CTRL_WIDTH-1:0]   w_wr_ctrl;
  logic                    data_full, desc_full;
  desc_t                   w_desc_in;

  assign w_limit    = ((r_wr_state == WR_IDLE) ? jumbo_en : r_jumbo) ? c_jumbo_bytes : c_max_bytes;
  assign w_cnt_next = r_cnt + 16'd1;
  assign w_over     = (w_cnt_next > w_limit);
  assign w_word_end = (r_lane == c_last_lane) || rx_eop;
  assign w_is_err   = rx_dvld && rx_eop && rx_err;
  assign w_ovf      = !w_is_err && ((w_word_end && data_full) || (rx_eop && desc_full));
  assign w_ctrl32   = ctrl_for_nbytes(6'(r_lane) + 6'd1, 6'(CTRL_WIDTH));
  assign w_ctrl_unused = ^w_ctrl32;
  assign w_wr_ctrl  = rx_eop ? w_ctrl32[CTRL_WIDTH-1:0] : '0;
  assign w_data_wr  = w_accept && w_word_end && !w_frame_drop && !w_is_err;
  assign w_desc_in  = '{byte_len: w_cnt_next, word_len: r_wcnt + 16'd1};

  // Write FSM next state and per-byte frame decisions
  always_comb begin
    w_wr_next    = r_wr_state;
    w_accept     = 1'b0;
    w_frame_drop = 1'b0;
    w_frame_good = 1'b0;
    w_frame_bad  = 1'b0;
    w_drop_eop   = 1'b0;
    w_word       = r_word;
    for (int l = 0; l < CTRL_WIDTH; l++) begin
      if (r_lane == LANE_W'(l)) begin
        w_word[DATA_WIDTH-1-8*l -: 8] = rx_data;
      end
    end
    case (r_wr_state)
      WR_SYNC: begin
        if (!rx_dvld) w_wr_next = WR_IDLE;
      end
      WR_IDLE, WR_RECV: begin
        if (rx_dvld) begin
          w_accept = 1'b1;
          if (w_over || w_ovf) begin
            w_frame_drop = 1'b1;
            w_drop_eop   = rx_eop;
            w_wr_next    = rx_eop ? WR_IDLE : WR_DROP;
          end else if (rx_eop) begin
            w_frame_bad  = rx_err;
            w_frame_good = !rx_err;
            w_wr_next    = WR_IDLE;
          end else begin
            w_wr_next = WR_RECV;
          end
        end
      end
      WR_DROP: begin
        if (rx_dvld && rx_eop) begin
          w_drop_eop = 1'b1;
          w_wr_next  = WR_IDLE;
        end
      end
      default: w_wr_next = WR_SYNC;
    endcase
  end

  // Write FSM state, packing registers and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_state  <= WR_SYNC;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_lane      <= '0;
      r_word      <= '0;
      r_jumbo     <= 1'b0;
      pkt_good    <= 1'b0;
      pkt_bad     <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      r_wr_state  <= w_wr_next;
      pkt_good    <= w_frame_good;
      pkt_bad     <= w_frame_bad;
      pkt_dropped <= w_drop_eop;
      if ((r_wr_state == WR_IDLE) && rx_dvld) begin
        r_jumbo <= jumbo_en;
      end
      if (w_accept && !w_frame_drop && !rx_eop) begin
        r_cnt <= w_cnt_next;
        if (r_lane == c_last_lane) begin
          r_lane <= '0;
          r_word <= '0;
          r_wcnt <= r_wcnt + 16'd1;
        end else begin
          r_lane <= r_lane + LANE_W'(1);
          r_word <= w_word;
        end
      end else if (w_accept || (r_wr_state != WR_RECV)) begin
        r_cnt  <= '0;
        r_wcnt <= '0;
        r_lane <= '0;
        r_word <= '0;
      end
    end
  end

  // ---------------- buffers ----------------
  logic [FW-1:0] data_dout;
  logic          data_valid, data_pop;
  logic [31:0]   desc_dout;
  logic          desc_valid, desc_pop;
  desc_t         w_desc;

  assign w_desc = desc_dout;

  rollback_fifo #(.WIDTH(FW), .DEPTH(DEPTH_WORDS)) u_data_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (w_data_wr),
    .wr_data  ({w_wr_ctrl, w_word}),
    .commit   (w_frame_good),
    .rollback (w_frame_bad || w_frame_drop),
    .rd_en    (data_pop),
    .rd_data  (data_dout),
    .rd_valid (data_valid),
    .full     (data_full)
  );

  rollback_fifo #(.WIDTH(32), .DEPTH(LEN_FIFO_DEPTH)) u_desc_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (w_frame_good),
    .wr_data  (w_desc_in),
    .commit   (1'b1),
    .rollback (1'b0),
    .rd_en    (desc_pop),
    .rd_data  (desc_dout),
    .rd_valid (desc_valid),
    .full     (desc_full)
  );

  // ---------------- read side ----------------
  rd_state_t             r_rd_state, w_rd_next;
  logic [15:0]           r_words_left;
  logic [HDR_BITS-1:0]   w_hdr64;
  logic [DATA_WIDTH-1:0] w_hdr;
  logic                  w_out_valid;

  // Header word fields placed at their package-defined offsets
  always_comb begin
    w_hdr64 = '0;
    w_hdr64[HDR_WORD_LEN_LSB +: 16] = w_desc.word_len;
    w_hdr64[HDR_PORT_LSB     +: 16] = c_port;
    w_hdr64[HDR_BYTE_LEN_LSB +: 16] = w_desc.byte_len;
  end

  if (DATA_WIDTH > HDR_BITS) begin : g_hdr_wide
    assign w_hdr = {w_hdr64, {(DATA_WIDTH-HDR_BITS){1'b0}}};
  end else if (DATA_WIDTH == HDR_BITS) begin : g_hdr_exact
    assign w_hdr = w_hdr64;
  end else begin : g_hdr_narrow
    logic [HDR_BITS-DATA_WIDTH-1:0] w_hdr_unused;
    assign w_hdr        = w_hdr64[HDR_BITS-1 -: DATA_WIDTH];
    assign w_hdr_unused = w_hdr64[HDR_BITS-DATA_WIDTH-1:0];
  end

  // Read FSM next state and output word selection
  always_comb begin
    w_rd_next   = r_rd_state;
    w_out_valid = 1'b0;
    data_pop    = 1'b0;
    desc_pop    = 1'b0;
    out_data    = '0;
    out_ctrl    = '0;
    case (r_rd_state)
      RD_IDLE: begin
        if (desc_valid) w_rd_next = (ENABLE_HEADER != 0) ? RD_HDR : RD_DATA;
      end
      RD_HDR: begin
        w_out_valid = 1'b1;
        out_data    = w_hdr;
        out_ctrl    = c_stage;
        if (out_rdy) w_rd_next = RD_DATA;
      end
      RD_DATA: begin
        if (data_valid) begin
          w_out_valid = 1'b1;
          out_data    = data_dout[DATA_WIDTH-1:0];
          out_ctrl    = data_dout[FW-1 -: CTRL_WIDTH];
          if (out_rdy) begin
            data_pop = 1'b1;
            if (r_words_left == 16'd1) begin
              desc_pop  = 1'b1;
              w_rd_next = RD_IDLE;
            end
          end
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  assign out_wr = w_out_valid && out_rdy;

  // Read FSM state and remaining data-word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state   <= RD_IDLE;
      r_words_left <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if ((r_rd_state == RD_IDLE) && desc_valid) begin
        r_words_left <= w_desc.word_len;
      end else if (data_pop) begin
        r_words_left <= r_words_left - 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmac_rx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmac_rx_packer
// Description : Directed self-checking bench for gmac_rx_packer (64-bit)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmac_rx_packer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_dvld, rx_eop, rx_err, jumbo_en;
  logic        rdy_a, rdy_b;
  logic [63:0] a_data, b_data;
  logic [7:0]  a_ctrl, b_ctrl;
  logic        a_wr, b_wr, a_good, b_good, a_bad, b_bad, a_drop, b_drop;

  int n_cmp  = 0;
  int n_fail = 0;
  int good_a = 0, bad_a = 0, drop_a = 0;
  int good_b = 0, bad_b = 0, drop_b = 0;
  word_t qa[$];
  word_t qb[$];
  word_t qs[$];

  always #5 clk = ~clk;

  gmac_rx_packer u_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_dvld(rx_dvld),
    .rx_eop(rx_eop), .rx_err(rx_err), .jumbo_en(jumbo_en),
    .out_data(a_data), .out_ctrl(a_ctrl), .out_wr(a_wr), .out_rdy(rdy_a),
    .pkt_good(a_good), .pkt_bad(a_bad), .pkt_dropped(a_drop)
  );

  gmac_rx_packer #(.DEPTH_WORDS(16)) u_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_dvld(rx_dvld),
    .rx_eop(rx_eop), .rx_err(rx_err), .jumbo_en(jumbo_en),
    .out_data(b_data), .out_ctrl(b_ctrl), .out_wr(b_wr), .out_rdy(rdy_b),
    .pkt_good(b_good), .pkt_bad(b_bad), .pkt_dropped(b_drop)
  );

  // Output monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (a_wr) qa.push_back('{a_data, a_ctrl});
      if (b_wr) qb.push_back('{b_data, b_ctrl});
      good_a += int'(a_good); bad_a += int'(a_bad); drop_a += int'(a_drop);
      good_b += int'(b_good); bad_b += int'(b_bad); drop_b += int'(b_drop);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int len, input logic [7:0] base, input int w);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < 8; l++) begin
      if (w*8 + l < len) v[63-8*l -: 8] = base + 8'(w*8 + l);
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_ctrl(input int len, input int w);
    int nw;
    nw = (len + 7) / 8;
    if (w != nw - 1) return 8'h00;
    return 8'h80 >> (len - 8*(nw-1) - 1);
  endfunction

  // Check one frame (header + data) in qs starting at index s
  task automatic chk_frame(input string tag, input int len, input logic [7:0] base, input int s);
    int nw;
    nw = (len + 7) / 8;
    chk({tag, " hdr"}, qs[s].d, {16'(nw), 16'h0, 16'h0, 16'(len)});
    chk({tag, " hdr ctrl"}, 64'(qs[s].c), 64'hFF);
    for (int w = 0; w < nw; w++) begin
      chk($sformatf("%s data%0d", tag, w), qs[s+1+w].d, exp_word(len, base, w));
      chk($sformatf("%s ctrl%0d", tag, w), 64'(qs[s+1+w].c), 64'(exp_ctrl(len, w)));
    end
  endtask

  task automatic wait_words(input int sel, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((((sel == 0) ? qa.size() : qb.size()) < n) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    chk({tag, " word count reached"}, 64'((sel == 0) ? qa.size() : qb.size()) >= 64'(n) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic send(input int len, input logic [7:0] base, input logic eop_last, input logic err);
    for (int i = 0; i < len; i++) begin
      rx_data = base + 8'(i);
      rx_dvld = 1'b1;
      rx_eop  = eop_last && (i == len - 1);
      rx_err  = err && (i == len - 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    rx_dvld = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete();
  endtask

  initial begin
    reset = 1'b0; rx_data = 8'h00; rx_dvld = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
    jumbo_en = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset out_wr", 64'(a_wr), 64'd0);
    chk("reset out_data", a_data, 64'd0);
    chk("reset out_ctrl", 64'(a_ctrl), 64'd0);
    chk("reset pulses", 64'({a_good, a_bad, a_drop}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(3);

    // 60-byte good frame
    send(60, 8'h10, 1'b1, 1'b0);
    idle(1);
    wait_words(0, 9, 300, "f60");
    idle(10);
    qs = qa;
    chk("f60 count", 64'(qa.size()), 64'd9);
    chk("f60 hdr literal", qs[0].d, 64'h0008_0000_0000_003C);
    chk("f60 last ctrl", 64'(qs[8].c), 64'h10);
    chk_frame("f60", 60, 8'h10, 0);
    chk("f60 pkt_good", 64'(good_a), 64'd1);
    clear_q();

    // 1-byte frame
    send(1, 8'hAB, 1'b1, 1'b0);
    idle(1);
    wait_words(0, 2, 300, "f1");
    idle(10);
    qs = qa;
    chk("f1 count", 64'(qa.size()), 64'd2);
    chk("f1 hdr", qs[0].d, 64'h0001_0000_0000_0001);
    chk("f1 data", qs[1].d, 64'hAB00_0000_0000_0000);
    chk("f1 ctrl", 64'(qs[1].c), 64'h80);
    clear_q();

    // Errored 64-byte frame followed by a good 64-byte frame
    send(64, 8'h40, 1'b1, 1'b1);
    send(64, 8'h80, 1'b1, 1'b0);
    idle(1);
    wait_words(0, 9, 300, "err");
    idle(20);
    qs = qa;
    chk("err count", 64'(qa.size()), 64'd9);
    chk("err last ctrl", 64'(qs[8].c), 64'h01);
    chk_frame("err good", 64, 8'h80, 0);
    chk("err pkt_bad", 64'(bad_a), 64'd1);
    chk("err pkt_good", 64'(good_a), 64'd3);
    clear_q();

    // Oversize 1519-byte frame, then the same with jumbo enabled
    jumbo_en = 1'b0;
    send(1519, 8'h00, 1'b1, 1'b0);
    idle(100);
    chk("oversize no output", 64'(qa.size()), 64'd0);
    chk("oversize pkt_dropped", 64'(drop_a), 64'd1);
    chk("oversize pkt_good", 64'(good_a), 64'd3);
    jumbo_en = 1'b1;
    send(1519, 8'h00, 1'b1, 1'b0);
    jumbo_en = 1'b0;
    idle(1);
    wait_words(0, 191, 800, "jumbo");
    idle(10);
    qs = qa;
    chk("jumbo count", 64'(qa.size()), 64'd191);
    chk("jumbo hdr literal", qs[0].d, 64'h00BE_0000_0000_05EF);
    chk("jumbo last ctrl", 64'(qs[190].c), 64'h02);
    chk_frame("jumbo", 1519, 8'h00, 0);
    chk("jumbo pkt_good", 64'(good_a), 64'd4);
    clear_q();

    // Small buffer overflow: three back-to-back frames with out_rdy low
    good_b = 0; bad_b = 0; drop_b = 0;
    rdy_b = 1'b0;
    send(64, 8'h01, 1'b1, 1'b0);
    send(64, 8'h41, 1'b1, 1'b0);
    send(64, 8'h81, 1'b1, 1'b0);
    idle(5);
    chk("ovf pkt_good", 64'(good_b), 64'd2);
    chk("ovf pkt_dropped", 64'(drop_b), 64'd1);
    chk("ovf stalled", 64'(qb.size()), 64'd0);
    rdy_b = 1'b1;
    wait_words(1, 18, 300, "ovf");
    idle(20);
    qs = qb;
    chk("ovf count", 64'(qb.size()), 64'd18);
    chk_frame("ovf f1", 64, 8'h01, 0);
    chk_frame("ovf f2", 64, 8'h41, 9);
    clear_q();

    // Reset mid-frame, released with rx_dvld still high
    send(20, 8'h30, 1'b0, 1'b0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h50 + 8'(i); rx_dvld = 1'b1;
      @(negedge clk);
      chk("mid-reset out", {a_data[63:8], a_wr, a_good, a_bad, a_drop, 4'(a_ctrl)}, 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    good_a = 0;
    send(10, 8'h60, 1'b1, 1'b0);
    idle(3);
    send(16, 8'hC0, 1'b1, 1'b0);
    idle(1);
    wait_words(0, 3, 300, "post-reset");
    idle(10);
    qs = qa;
    chk("post-reset count", 64'(qa.size()), 64'd3);
    chk("post-reset hdr literal", qs[0].d, 64'h0002_0000_0000_0010);
    chk_frame("post-reset", 16, 8'hC0, 0);
    chk("post-reset pkt_good", 64'(good_a), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
